display_scan_driver: RTL and testbench
======================================

Name: display_scan_driver

Overview:
- Parametrised, time-multiplexed seven-segment display driver for the Nexys A7 (8 common-anode digits), generalised to N digits.
- Scans digits with a prescaled refresh counter and drives active-low one-hot anodes.
- Decodes hex nibbles to active-low segments; supports decimal points, per-digit blanking and PWM brightness.
- Loaded data is double-buffered and committed only at frame boundaries, so the display never tears.

Parameters:
- N_DIGITS, 8, number of digits scanned (1..16).
- DIV_W, 17, log2 of clock cycles per digit slot; slot length = 2^DIV_W.
- BRIGHT_W, 4, brightness resolution in bits; requires BRIGHT_W <= DIV_W.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- data_in  in  4*N_DIGITS  hex nibble per digit; digit i = data_in[4i+3:4i].
- dp_in  in  N_DIGITS  decimal point request per digit, 1 = lit.
- blank_in  in  N_DIGITS  per-digit blank, 1 = digit dark.
- load  in  1  single-cycle strobe; captures data_in, dp_in and blank_in into the pending buffer.
- brightness  in  BRIGHT_W  duty level; 0 = minimum, all-ones = maximum.
- an_out  out  N_DIGITS  anodes, active-low, at most one low.
- seg_out  out  7  segments, active-low; bit0 = CA ... bit6 = CG.
- dp_out  out  1  decimal point, active-low.
- digit_idx  out  $clog2(N_DIGITS) (min 1)  index of the slot currently on an_out.
- frame_tick  out  1  one-cycle pulse at the start of the digit-0 slot.

Behaviour:
Reset values (asynchronous, all outputs):
- an_out all 1, seg_out 7'h7F, dp_out 1, digit_idx 0, frame_tick 0.
- Prescaler 0, internal index 0.
- Pending and active buffers: data 0, dp 0, blank all 1 (dark until the first load commits).

Scan timing:
- Prescaler cnt (DIV_W bits) increments every cycle and wraps naturally.
- When cnt = all-ones, idx advances: idx = N_DIGITS-1 wraps to 0. Non-power-of-2 N_DIGITS must wrap explicitly.
- Frame boundary = the cycle in which idx wraps to 0.

Buffering:
- load = 1 captures the inputs into the pending buffer and sets a pending flag.
- At a frame boundary with the pending flag set, pending is copied to active and the flag clears.
- load coincident with a frame boundary: the newly captured values go straight to active for the new frame.
- Repeated loads within one frame: the last one wins.

PWM and dead time:
- phase = cnt[DIV_W-1 -: BRIGHT_W].
- Digit lit iff cnt != 0 (one dead cycle per slot for anti-ghosting) AND phase <= brightness AND active blank[idx] = 0.
- Lit: an_out = ~(1 << idx). Not lit: an_out all 1.

Decode:
- Active-low table, bit6..bit0 = g..a:
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000
  - 4=0011001, 5=0010010, 6=0000010, 7=1111000
  - 8=0000000, 9=0010000, A=0001000, b=0000011
  - C=1000110, d=0100001, E=0000110, F=0001110
- seg_out = 7'h7F and dp_out = 1 whenever the digit is not lit.
- dp_out = ~active dp[idx] when lit.

Latency and alignment:
- an_out, seg_out, dp_out, digit_idx and frame_tick are registered: one cycle after the internal cnt/idx state that produced them.
- digit_idx is always aligned with an_out.
- frame_tick is high for exactly the first cycle in which digit_idx = 0 after a wrap. It does not pulse for the first slot after reset.

Reset mid-operation:
- Asserting reset returns all outputs to reset values immediately.
- Buffers are cleared; a pending load is discarded.

Test Plan:
All scenarios use N_DIGITS=4, DIV_W=4, BRIGHT_W=2.
1. Reset asserted mid-scan -> an_out=4'b1111, seg_out=7'h7F, dp_out=1, digit_idx=0 in the same cycle. No output toggles while reset is held.
2. load data_in=16'h3210, blank_in=0, brightness=3, then wait for a frame boundary:
   - an_out cycles 1110 -> 1101 -> 1011 -> 0111, each low for 15 of 16 cycles.
   - seg_out = 1000000 in slot 0, 1111001 in slot 1, 0100100 in slot 2, 0110000 in slot 3.
3. Free run for 256 cycles -> frame_tick pulses exactly once every 64 cycles, coincident with the first cycle of the digit_idx=0 slot.
4. brightness=0 -> each digit lit only at cnt=1..3: 3 cycles per slot; an_out all 1 for the remaining 13 cycles.
5. Active = 16'h3210, then load 16'hFFFF during slot 1:
   - Slots 1-3 keep showing 1, 2, 3; the next frame shows 0001110 on all digits.
   - A load on the boundary cycle shows the new data in that frame's slot 0.
6. blank_in=4'b0100, dp_in=4'b0001 -> an_out stays 4'b1111 and seg_out stays 7'h7F throughout slot 2; dp_out=0 only while digit 0 is lit.

Source files
------------

// File: rtl/display_scan_driver.sv
// ---------------------------------------------------------------------------
// display_scan_driver
//
// Time-multiplexed seven-segment display driver for N_DIGITS common-anode
// digits. A free-running prescaler divides each digit slot into 2^DIV_W
// cycles. A digit index steps once per slot. For the digit in the current
// slot, the driver decodes its hex nibble to active-low segments and drives
// the matching active-low anode. Decimal points, per-digit blanking and PWM
// brightness are supported.
//
// Display data is double-buffered. A load captures into a pending buffer,
// which is copied to the active buffer only at a frame boundary (the cycle
// in which the index wraps to 0). A frame therefore always shows one
// consistent set of values.
//
// Parameters
//   N_DIGITS  number of digits scanned (1..16)
//   DIV_W     log2 of clock cycles per digit slot
//   BRIGHT_W  brightness resolution in bits (BRIGHT_W <= DIV_W)
//
// Ports
//   clk         system clock
//   reset       asynchronous, active-high reset
//   data_in     hex nibble per digit, digit i = data_in[4i+3:4i]
//   dp_in       decimal point request per digit, 1 = lit
//   blank_in    per-digit blank, 1 = digit dark
//   load        single-cycle strobe capturing data_in/dp_in/blank_in
//   brightness  PWM duty level, 0 = minimum, all-ones = maximum
//   an_out      anodes, active-low, at most one low
//   seg_out     segments, active-low, bit0 = CA ... bit6 = CG
//   dp_out      decimal point, active-low
//   digit_idx   index of the slot currently shown on an_out
//   frame_tick  one-cycle pulse at the start of each digit-0 slot after a wrap
//
// Interface note: load is a plain strobe with no ready signal. Every cycle
// with load = 1 is a capture. Within one frame, the last capture wins.
// ---------------------------------------------------------------------------
module display_scan_driver #(
    parameter int N_DIGITS = 8,
    parameter int DIV_W    = 17,
    parameter int BRIGHT_W = 4,
    localparam int IDX_W   = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [4*N_DIGITS-1:0] data_in,
    input  logic [N_DIGITS-1:0]   dp_in,
    input  logic [N_DIGITS-1:0]   blank_in,
    input  logic                  load,
    input  logic [BRIGHT_W-1:0]   brightness,
    output logic [N_DIGITS-1:0]   an_out,
    output logic [6:0]            seg_out,
    output logic                  dp_out,
    output logic [IDX_W-1:0]      digit_idx,
    output logic                  frame_tick
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_DIGITS - 1);

    // Active-low hex decode, bit6..bit0 = g..a.
    function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
        logic [6:0] s;
        case (nib)
            4'h0:    s = 7'b1000000;
            4'h1:    s = 7'b1111001;
            4'h2:    s = 7'b0100100;
            4'h3:    s = 7'b0110000;
            4'h4:    s = 7'b0011001;
            4'h5:    s = 7'b0010010;
            4'h6:    s = 7'b0000010;
            4'h7:    s = 7'b1111000;
            4'h8:    s = 7'b0000000;
            4'h9:    s = 7'b0010000;
            4'hA:    s = 7'b0001000;
            4'hB:    s = 7'b0000011;
            4'hC:    s = 7'b1000110;
            4'hD:    s = 7'b0100001;
            4'hE:    s = 7'b0000110;
            default: s = 7'b0001110;
        endcase
        return s;
    endfunction

    // Scan state
    logic [DIV_W-1:0]      cnt_q, cnt_d;
    logic [IDX_W-1:0]      idx_q, idx_d;

    // Pending buffer and its flag
    logic [4*N_DIGITS-1:0] data_pend_q, data_pend_d;
    logic [N_DIGITS-1:0]   dp_pend_q, dp_pend_d;
    logic [N_DIGITS-1:0]   blank_pend_q, blank_pend_d;
    logic                  pend_flag_q, pend_flag_d;

    // Active buffer, which is what is displayed
    logic [4*N_DIGITS-1:0] data_act_q, data_act_d;
    logic [N_DIGITS-1:0]   dp_act_q, dp_act_d;
    logic [N_DIGITS-1:0]   blank_act_q, blank_act_d;

    // Frame boundary delayed by one cycle, so frame_tick lines up with digit_idx
    logic                  wrap_q, wrap_d;

    // Registered outputs
    logic [N_DIGITS-1:0]   an_q, an_d;
    logic [6:0]            seg_q, seg_d;
    logic                  dp_out_q, dp_out_d;
    logic [IDX_W-1:0]      digit_idx_q, digit_idx_d;
    logic                  frame_tick_q, frame_tick_d;

    // Combinational helpers
    logic                  slot_end;
    logic                  frame_boundary;
    logic [BRIGHT_W-1:0]   phase;
    logic                  lit;
    logic [3:0]            nibble;

    always_comb begin
        slot_end       = (cnt_q == '1);
        frame_boundary = slot_end && (idx_q == LAST_IDX);
        phase          = cnt_q[DIV_W-1 -: BRIGHT_W];
        nibble         = data_act_q[4*idx_q +: 4];

        // Cycle 0 of every slot is dark. This dead time lets the previous
        // anode turn off before the new segments appear, which avoids ghosting.
        lit = (cnt_q != '0) && (phase <= brightness) && !blank_act_q[idx_q];

        // Prescaler wraps naturally. The index wraps explicitly, because
        // N_DIGITS need not be a power of two.
        cnt_d = cnt_q + DIV_W'(1);
        idx_d = idx_q;
        if (slot_end) begin
            idx_d = (idx_q == LAST_IDX) ? '0 : idx_q + IDX_W'(1);
        end

        // Buffering
        data_pend_d  = data_pend_q;
        dp_pend_d    = dp_pend_q;
        blank_pend_d = blank_pend_q;
        pend_flag_d  = pend_flag_q;
        data_act_d   = data_act_q;
        dp_act_d     = dp_act_q;
        blank_act_d  = blank_act_q;

        if (load) begin
            data_pend_d  = data_in;
            dp_pend_d    = dp_in;
            blank_pend_d = blank_in;
            pend_flag_d  = 1'b1;
        end

        // A load on the boundary cycle bypasses pending, so it is shown in
        // the frame that is just starting.
        if (frame_boundary && (load || pend_flag_q)) begin
            data_act_d  = load ? data_in  : data_pend_q;
            dp_act_d    = load ? dp_in    : dp_pend_q;
            blank_act_d = load ? blank_in : blank_pend_q;
            pend_flag_d = 1'b0;
        end

        // Outputs, registered one cycle after the scan state that produced them
        an_d     = '1;
        seg_d    = 7'h7F;
        dp_out_d = 1'b1;
        if (lit) begin
            an_d[idx_q] = 1'b0;
            seg_d       = hex_to_seg(nibble);
            dp_out_d    = ~dp_act_q[idx_q];
        end
        digit_idx_d  = idx_q;
        wrap_d       = frame_boundary;
        frame_tick_d = wrap_q;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q        <= '0;
            idx_q        <= '0;
            data_pend_q  <= '0;
            dp_pend_q    <= '0;
            blank_pend_q <= '1;
            pend_flag_q  <= 1'b0;
            data_act_q   <= '0;
            dp_act_q     <= '0;
            blank_act_q  <= '1;
            wrap_q       <= 1'b0;
            an_q         <= '1;
            seg_q        <= 7'h7F;
            dp_out_q     <= 1'b1;
            digit_idx_q  <= '0;
            frame_tick_q <= 1'b0;
        end else begin
            cnt_q        <= cnt_d;
            idx_q        <= idx_d;
            data_pend_q  <= data_pend_d;
            dp_pend_q    <= dp_pend_d;
            blank_pend_q <= blank_pend_d;
            pend_flag_q  <= pend_flag_d;
            data_act_q   <= data_act_d;
            dp_act_q     <= dp_act_d;
            blank_act_q  <= blank_act_d;
            wrap_q       <= wrap_d;
            an_q         <= an_d;
            seg_q        <= seg_d;
            dp_out_q     <= dp_out_d;
            digit_idx_q  <= digit_idx_d;
            frame_tick_q <= frame_tick_d;
        end
    end

    assign an_out     = an_q;
    assign seg_out    = seg_q;
    assign dp_out     = dp_out_q;
    assign digit_idx  = digit_idx_q;
    assign frame_tick = frame_tick_q;

endmodule

// File: tb/tb_display_scan_driver.sv
// ---------------------------------------------------------------------------
// tb_display_scan_driver
//
// Bench for display_scan_driver with N_DIGITS=4, DIV_W=4, BRIGHT_W=2.
// The driver applies inputs on the falling edge. For each cycle it pushes
// the expected output word into exp_q. The monitor pops one entry after
// every rising edge and compares it with the DUT outputs.
//
// The reference model works from elapsed cycles since reset:
//   slot     = k / 16
//   digit    = slot % 4
//   position = k % 16
//   frame    = k / 64
// The active data for a frame is whatever was last loaded before that
// frame began.
// ---------------------------------------------------------------------------
module tb_display_scan_driver;

    localparam int N  = 4;
    localparam int DW = 4;
    localparam int BW = 2;
    localparam int SLOT  = 1 << DW;
    localparam int FRAME = SLOT * N;
    localparam int EW = N + 7 + 1 + 2 + 1;

    logic            clk = 1'b0;
    logic            reset = 1'b1;
    logic [4*N-1:0]  data_in = '0;
    logic [N-1:0]    dp_in = '0;
    logic [N-1:0]    blank_in = '0;
    logic            load = 1'b0;
    logic [BW-1:0]   brightness = '0;
    logic [N-1:0]    an_out;
    logic [6:0]      seg_out;
    logic            dp_out;
    logic [1:0]      digit_idx;
    logic            frame_tick;

    int checks = 0;
    int errors = 0;

    logic [EW-1:0] exp_q[$];

    // Values from the decode table
    logic [6:0] seg_tab [16] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
        7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
    };

    // Reference model state
    int             mk;
    logic [4*N-1:0] act_data, lat_data;
    logic [N-1:0]   act_dp, lat_dp, act_blank, lat_blank;

    // Current stimulus values, held between steps
    logic [4*N-1:0] cur_data;
    logic [N-1:0]   cur_dp, cur_blank;
    logic [BW-1:0]  cur_br;

    display_scan_driver #(.N_DIGITS(N), .DIV_W(DW), .BRIGHT_W(BW)) dut (
        .clk        (clk),
        .reset      (reset),
        .data_in    (data_in),
        .dp_in      (dp_in),
        .blank_in   (blank_in),
        .load       (load),
        .brightness (brightness),
        .an_out     (an_out),
        .seg_out    (seg_out),
        .dp_out     (dp_out),
        .digit_idx  (digit_idx),
        .frame_tick (frame_tick)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- model ----------------
    task automatic model_reset();
        mk        = 0;
        act_data  = '0;
        act_dp    = '0;
        act_blank = '1;
        lat_data  = '0;
        lat_dp    = '0;
        lat_blank = '1;
    endtask

    // Drive one cycle of inputs (called just after a falling edge), push the
    // expected output for the following rising edge, then wait for the next
    // falling edge.
    task automatic step(input logic ld);
        int pos;
        int dig;
        logic lit_m;
        logic [N-1:0] e_an;
        logic [6:0] e_seg;
        logic e_dp;
        logic e_tick;
        logic [3:0] nib;

        load       = ld;
        data_in    = cur_data;
        dp_in      = cur_dp;
        blank_in   = cur_blank;
        brightness = cur_br;

        // At the start of each frame after the first, the display shows the
        // latest data loaded before that frame began.
        if (mk > 0 && (mk % FRAME) == 0) begin
            act_data  = lat_data;
            act_dp    = lat_dp;
            act_blank = lat_blank;
        end

        pos   = mk % SLOT;
        dig   = (mk / SLOT) % N;
        lit_m = (pos != 0) && ((pos / (SLOT >> BW)) <= int'(cur_br)) && !act_blank[dig];
        nib   = act_data[4*dig +: 4];

        e_an   = '1;
        e_seg  = 7'h7F;
        e_dp   = 1'b1;
        if (lit_m) begin
            e_an[dig] = 1'b0;
            e_seg     = seg_tab[nib];
            e_dp      = ~act_dp[dig];
        end
        e_tick = (mk > 0) && ((mk % FRAME) == 0);
        exp_q.push_back({e_an, e_seg, e_dp, 2'(dig), e_tick});

        if (ld) begin
            lat_data  = cur_data;
            lat_dp    = cur_dp;
            lat_blank = cur_blank;
        end
        mk++;
        @(negedge clk);
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step(1'b0);
    endtask

    task automatic drain(input string name);
        for (int i = 0; i < 4 && exp_q.size() != 0; i++) @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL %s: queue holds %0d entries, required 0", name, exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic check_reset_outputs(input string name);
        checks++;
        if (an_out !== 4'hF || seg_out !== 7'h7F || dp_out !== 1'b1 ||
            digit_idx !== 2'd0 || frame_tick !== 1'b0) begin
            errors++;
            $display("FAIL %s: got an=%b seg=%b dp=%b idx=%0d tick=%b, required an=1111 seg=1111111 dp=1 idx=0 tick=0",
                     name, an_out, seg_out, dp_out, digit_idx, frame_tick);
        end
    endtask

    // ---------------- monitor / scoreboard ----------------
    initial begin
        logic [EW-1:0] e;
        logic [EW-1:0] got;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e   = exp_q.pop_front();
                got = {an_out, seg_out, dp_out, digit_idx, frame_tick};
                checks++;
                if (got !== e) begin
                    errors++;
                    $display("FAIL scan_out t=%0t: got an=%b seg=%b dp=%b idx=%0d tick=%b, required an=%b seg=%b dp=%b idx=%0d tick=%b",
                             $time, got[EW-1 -: N], got[10:4], got[3], got[2:1], got[0],
                             e[EW-1 -: N], e[10:4], e[3], e[2:1], e[0]);
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        model_reset();
        cur_data  = '0;
        cur_dp    = '0;
        cur_blank = '0;
        cur_br    = 2'd3;

        repeat (3) @(negedge clk);
        check_reset_outputs("reset_initial");
        reset = 1'b0;

        // Power-up: load 3210 at full brightness, then scan three frames
        cur_data = 16'h3210;
        step(1'b1);
        run(3*FRAME - 1);

        // Minimum brightness: 3 lit cycles per slot
        cur_br = 2'd0;
        run(2*FRAME);
        cur_br = 2'd2;
        run(FRAME);
        cur_br = 2'd3;

        // Load during slot 1 is deferred to the next frame. A load on the
        // boundary cycle is shown in the new frame's slot 0.
        for (int i = 0; i < 3*FRAME; i++) begin
            cur_data = (i < FRAME) ? 16'hFFFF : 16'hABCD;
            step(((i < FRAME) && (mk % FRAME) == 20) ||
                 ((i >= FRAME) && (i < 2*FRAME) && (mk % FRAME) == FRAME - 1));
        end

        // Blanking and decimal point
        cur_data  = 16'h3210;
        cur_blank = 4'b0100;
        cur_dp    = 4'b0001;
        step(1'b1);
        run(2*FRAME);

        // Randomized traffic, with occasional repeated loads in a frame
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(49, 0) == 0) cur_br = BW'($urandom_range(3, 0));
            if ($urandom_range(15, 0) == 0) begin
                cur_data  = 16'($urandom);
                cur_dp    = 4'($urandom_range(15, 0));
                cur_blank = ($urandom_range(3, 0) == 0) ? 4'($urandom_range(15, 0)) : 4'b0000;
                step(1'b1);
            end else begin
                step(1'b0);
            end
        end
        drain("drain_before_reset");

        // Reset asserted mid-scan, between clock edges
        #2;
        reset = 1'b1;
        #1;
        check_reset_outputs("reset_async");
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_reset_outputs("reset_held");
        end
        model_reset();
        reset = 1'b0;

        // After reset, the display is dark until a load commits at a frame boundary
        run(FRAME + 10);
        cur_data  = 16'h9A5C;
        cur_dp    = 4'b1010;
        cur_blank = 4'b0000;
        cur_br    = 2'd1;
        step(1'b1);
        run(2*FRAME);
        drain("drain_final");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Overall time limit
    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
